// File: rtl/gridding_sched.sv
// gridding_sched: visibility sample scheduler that reorders kernel-overlapping samples through a deferral FIFO.
// Defining GRIDDING_SCHED_STATS_EN adds the stat_issued / stat_bubbles counter outputs.

module gridding_sched #(
    parameter int G_SIZE    = 128,
    parameter int SUPPORT   = 7,
    parameter int S_SIZE    = 15,
    parameter int IDX_W     = 16,
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 4,
    parameter int SIDX_W    = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IDX_W-1:0]                 in_iu,
    input  logic [IDX_W-1:0]                 in_iv,
    input  logic [31:0]                      in_offset,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [SIDX_W-1:0]                in_sidx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_gind,
    output logic [31:0]                      out_cind,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_first,
    output logic                             out_last,
    output logic [SIDX_W-1:0]                out_sidx,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
`ifdef GRIDDING_SCHED_STATS_EN
    output logic [31:0]                      stat_issued,
    output logic [31:0]                      stat_bubbles,
`endif
    output logic                             busy
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int RW = $clog2(S_SIZE + 1);
    localparam logic signed [IDX_W+1:0] L_SUP = (IDX_W+2)'(SUPPORT);
    localparam logic signed [IDX_W+1:0] L_SSZ = (IDX_W+2)'(S_SIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_ISSUE, ST_BUBBLE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  iu;
        logic [IDX_W-1:0]  iv;
        logic [31:0]       offset;
        logic [DATA_W-1:0] data;
        logic [SIDX_W-1:0] sidx;
    } entry_t;

    // Footprints overlap when both axis distances are below the kernel width.
    function automatic logic f_conflict(input logic pv,
                                        input logic [IDX_W-1:0] iu_c, input logic [IDX_W-1:0] iv_c,
                                        input logic [IDX_W-1:0] iu_p, input logic [IDX_W-1:0] iv_p);
        logic signed [IDX_W+1:0] cu_c, cu_p, du, dv;
        cu_c = $signed({2'b00, iu_c}) - L_SUP;
        cu_p = $signed({2'b00, iu_p}) - L_SUP;
        du   = cu_c - cu_p;
        dv   = $signed({2'b00, iv_c}) - $signed({2'b00, iv_p});
        if (du[IDX_W+1]) du = -du; else du = du;
        if (dv[IDX_W+1]) dv = -dv; else dv = dv;
        return pv && (du < L_SSZ) && (dv < L_SSZ);
    endfunction

    function automatic logic [31:0] f_gind(input logic [IDX_W-1:0] iu, input logic [IDX_W-1:0] iv);
        return 32'(iu) + 32'(iv) * 32'(G_SIZE) - 32'(SUPPORT);
    endfunction

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t            r_state;
    entry_t            r_buf [BUF_DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [IDX_W-1:0]  r_prev_iu, r_prev_iv, r_cur_iu, r_cur_iv;
    logic              r_prev_valid;
    logic [RW-1:0]     r_row, r_wait;
    logic              r_out_valid, r_out_first, r_out_last;
    logic [31:0]       r_out_gind, r_out_cind;
    logic [DATA_W-1:0] r_out_data;
    logic [SIDX_W-1:0] r_out_sidx;
`ifdef GRIDDING_SCHED_STATS_EN
    logic [31:0]       r_stat_issued, r_stat_bubbles;
`endif

    entry_t w_in_ent, w_head, w_issue;
    logic   w_empty, w_full, w_head_ok, w_in_ok, w_push, w_pop, w_sel_head, w_in_ready;
    state_t w_next;

    assign w_in_ent  = '{iu: in_iu, iv: in_iv, offset: in_offset, data: in_data, sidx: in_sidx};
    assign w_head    = r_buf[r_rd_ptr];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(BUF_DEPTH));
    assign w_head_ok = !w_empty && !f_conflict(r_prev_valid, w_head.iu, w_head.iv, r_prev_iu, r_prev_iv);
    assign w_in_ok   = in_valid && !f_conflict(r_prev_valid, in_iu, in_iv, r_prev_iu, r_prev_iv);
    assign w_issue   = w_sel_head ? w_head : w_in_ent;

    // DECIDE candidate selection; a pushed conflicting input keeps us in DECIDE so the next input can still go first.
    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_sel_head = 1'b0;
        w_in_ready = 1'b0;
        w_next     = r_state;
        if (r_state == ST_DECIDE) begin
            if (w_head_ok) begin
                w_sel_head = 1'b1;
                w_pop      = 1'b1;
                w_in_ready = !w_full;
                w_push     = in_valid && !w_full;
                w_next     = ST_ISSUE;
            end else if (w_in_ok) begin
                w_in_ready = 1'b1;
                w_next     = ST_ISSUE;
            end else if (in_valid && !w_full) begin
                w_in_ready = 1'b1;
                w_push     = 1'b1;
                w_next     = ST_DECIDE;
            end else if (in_valid || !w_empty) begin
                w_next     = ST_BUBBLE;
            end else begin
                w_next     = ST_IDLE;
            end
        end else begin
            w_next = r_state;
        end
    end

    // Deferral FIFO storage; occupancy is tracked by r_count so contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= w_in_ent;
        end
    end

    // Scheduler FSM, FIFO pointers, registered beat outputs and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_prev_iu    <= '0;
            r_prev_iv    <= '0;
            r_cur_iu     <= '0;
            r_cur_iv     <= '0;
            r_prev_valid <= 1'b0;
            r_row        <= '0;
            r_wait       <= '0;
            r_out_valid  <= 1'b0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_gind   <= '0;
            r_out_cind   <= '0;
            r_out_data   <= '0;
            r_out_sidx   <= '0;
`ifdef GRIDDING_SCHED_STATS_EN
            r_stat_issued  <= '0;
            r_stat_bubbles <= '0;
`endif
        end else begin
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);

            case (r_state)
                ST_IDLE: begin
                    if (in_valid || !w_empty) begin
                        r_state <= ST_DECIDE;
                        r_wait  <= '0;
                    end else if (r_wait == RW'(S_SIZE - 1)) begin
                        r_prev_valid <= 1'b0;
                    end else begin
                        r_wait <= r_wait + RW'(1);
                    end
                end
                ST_DECIDE: begin
                    r_state <= w_next;
                    r_wait  <= '0;
                    if (w_next == ST_ISSUE) begin
                        r_cur_iu    <= w_issue.iu;
                        r_cur_iv    <= w_issue.iv;
                        r_out_valid <= 1'b1;
                        r_out_gind  <= f_gind(w_issue.iu, w_issue.iv);
                        r_out_cind  <= w_issue.offset;
                        r_out_data  <= w_issue.data;
                        r_out_sidx  <= w_issue.sidx;
                        r_out_first <= 1'b1;
                        r_out_last  <= (S_SIZE == 1);
                        r_row       <= '0;
                    end else if (w_next == ST_BUBBLE) begin
`ifdef GRIDDING_SCHED_STATS_EN
                        r_stat_bubbles <= f_sat_inc(r_stat_bubbles);
`endif
                    end
                end
                ST_ISSUE: begin
                    if (r_out_valid && out_ready) begin
                        if (r_row == RW'(S_SIZE - 1)) begin
                            r_out_valid  <= 1'b0;
                            r_out_first  <= 1'b0;
                            r_out_last   <= 1'b0;
                            r_prev_iu    <= r_cur_iu;
                            r_prev_iv    <= r_cur_iv;
                            r_prev_valid <= 1'b1;
                            r_state      <= ST_DECIDE;
`ifdef GRIDDING_SCHED_STATS_EN
                            r_stat_issued <= f_sat_inc(r_stat_issued);
`endif
                        end else begin
                            r_row       <= r_row + RW'(1);
                            r_out_gind  <= r_out_gind + 32'(G_SIZE);
                            r_out_cind  <= r_out_cind + 32'(S_SIZE);
                            r_out_first <= 1'b0;
                            r_out_last  <= (r_row == RW'(S_SIZE - 2));
                        end
                    end
                end
                ST_BUBBLE: begin
                    if (r_wait == RW'(S_SIZE - 1)) begin
                        r_prev_valid <= 1'b0;
                        r_state      <= ST_DECIDE;
                    end else begin
                        r_wait <= r_wait + RW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_gind  = r_out_gind;
    assign out_cind  = r_out_cind;
    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign out_sidx  = r_out_sidx;
    assign buf_count = r_count;
    assign busy      = (r_state != ST_IDLE) || (r_count != '0);
`ifdef GRIDDING_SCHED_STATS_EN
    assign stat_issued  = r_stat_issued;
    assign stat_bubbles = r_stat_bubbles;
`endif

endmodule
